// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between an instruction-fetch port and a data port.
// Optional address-window checking is enabled by defining MEM_ARB_BOUNDS_CHECK_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] TEXT_LO      = 32'h0000_0000,
  parameter logic [31:0] TEXT_HI      = 32'h0000_0FFC,
  parameter logic [31:0] STACK_LO     = 32'h0000_1000,
  parameter logic [31:0] STACK_HI     = 32'h0000_1FFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_t;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          grant_if, grant_d;
  logic          if_bad, d_bad;
  logic          cur_we_q, cur_bad_q;
  logic [31:0]   if_rdata_q, d_rdata_q;
  logic [31:0]   resp_data;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  logic [31:0] if_addr_w, d_addr_w;
  assign if_addr_w = {if_addr[31:2], 2'b00};
  assign d_addr_w  = {d_addr[31:2], 2'b00};
  // Unsigned offset compare gives an inclusive window test without constant-folded bounds.
  assign if_bad = (if_addr_w - TEXT_LO) > (TEXT_HI - TEXT_LO);
  assign d_bad  = (d_addr_w - STACK_LO) > (STACK_HI - STACK_LO);
`else
  logic unused_bounds;
  assign unused_bounds = ^{TEXT_LO, TEXT_HI, STACK_LO, STACK_HI};
  assign if_bad = 1'b0;
  assign d_bad  = 1'b0;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == IDLE && !rst) begin
      if (if_req && d_req) begin
        if (starve_cnt == LIMIT) grant_if = 1'b1;
        else                     grant_d  = 1'b1;
      end else begin
        grant_if = if_req;
        grant_d  = d_req;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_if)     state_nxt = IF_WAIT;
        else if (grant_d) state_nxt = D_WAIT;
      end
      IF_WAIT, D_WAIT: state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // Writes and rejected accesses return zero instead of memory data.
  assign resp_data = (cur_we_q || cur_bad_q) ? 32'h0 : mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      cur_we_q   <= 1'b0;
      cur_bad_q  <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (grant_if) begin
        starve_cnt <= '0;
        cur_we_q   <= 1'b0;
        cur_bad_q  <= if_bad;
      end else if (grant_d) begin
        if (if_req && starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
        cur_we_q  <= d_we;
        cur_bad_q <= d_bad;
      end
      if (state == IF_WAIT) if_rdata_q <= resp_data;
      if (state == D_WAIT)  d_rdata_q  <= resp_data;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    err       = 1'b0;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (grant_if) begin
            mem_en   = !if_bad;
            mem_addr = {2'b00, if_addr[31:2]};
          end else if (grant_d) begin
            mem_en    = !d_bad;
            mem_we    = d_we && !d_bad;
            mem_addr  = {2'b00, d_addr[31:2]};
            mem_wdata = d_wdata;
          end
        end
        IF_WAIT: begin
          if_ready = 1'b1;
          if_rdata = resp_data;
          err      = cur_bad_q;
        end
        D_WAIT: begin
          d_ready = 1'b1;
          d_rdata = resp_data;
          err     = cur_bad_q;
        end
        default: ;
      endcase
    end
  end

  assign if_stall = if_req && !if_ready;
  assign d_stall  = d_req && !d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration and memory reference model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ready, if_stall, d_ready, d_stall;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem    [0:2047];
  logic [31:0] shadow [0:2047];

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: write at the access edge, read data one cycle later.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[10:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[10:0]];
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h10; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({mem_en, mem_we, if_ready, d_ready, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 00000", {mem_en, mem_we, if_ready, d_ready, err});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_bus: got %h/%h want 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (if_stall !== 1'b1) begin
      errors++; $display("FAIL reset_stall: got %b want 1", if_stall);
    end
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata);
    end
  endtask

  task automatic test_fetch();
    reset_dut();
    mem[2] <= 32'hDEAD_BEEF;
    shadow[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, if_stall, if_ready} !== {1'b1, 1'b0, 32'h2, 1'b1, 1'b0}) begin
      errors++; $display("FAIL fetch_grant: got en=%b we=%b addr=%h stall=%b rdy=%b want 1 0 2 1 0",
                         mem_en, mem_we, mem_addr, if_stall, if_ready);
    end
    @(negedge clk); #1;
    checks++;
    if ({if_ready, if_rdata, mem_en, if_stall} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fetch_resp: got rdy=%b data=%h en=%b stall=%b want 1 deadbeef 0 0",
                         if_ready, if_rdata, mem_en, if_stall);
    end
    if_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({if_ready, if_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL fetch_hold: got rdy=%b data=%h want 0 deadbeef", if_ready, if_rdata);
    end
  endtask

  task automatic test_write_read();
    reset_dut();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1004; d_wdata = 32'h1234_5678;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h401, 32'h1234_5678}) begin
      errors++; $display("FAIL wr_grant: got en=%b we=%b addr=%h wdata=%h want 1 1 401 12345678",
                         mem_en, mem_we, mem_addr, mem_wdata);
    end
    shadow[32'h401] = 32'h1234_5678;
    @(negedge clk); #1;
    checks++;
    if ({d_ready, d_rdata, err} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL wr_resp: got rdy=%b data=%h err=%b want 1 0 0", d_ready, d_rdata, err);
    end
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h1005;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h401}) begin
      errors++; $display("FAIL rd_grant: got en=%b we=%b addr=%h want 1 0 401", mem_en, mem_we, mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, 32'h1234_5678}) begin
      errors++; $display("FAIL rd_resp: got rdy=%b data=%h want 1 12345678", d_ready, d_rdata);
    end
    d_req = 1'b0;
  endtask

  task automatic test_starve();
    reset_dut();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1010;
    for (int c = 0; c < 20; c++) begin
      logic        exp_en, exp_if_rdy;
      logic [31:0] exp_addr;
      int          g;
      if (c > 0) @(negedge clk);
      #1;
      g          = c / 2;
      exp_en     = (c % 2) == 0;
      exp_addr   = (g % 5 == 4) ? 32'h4 : 32'h404;
      exp_if_rdy = (c % 2 == 1) && (g % 5 == 4);
      checks++;
      if (mem_en !== exp_en || (exp_en && mem_addr !== exp_addr)) begin
        errors++; $display("FAIL starve_grant c=%0d: got en=%b addr=%h want en=%b addr=%h",
                           c, mem_en, mem_addr, exp_en, exp_addr);
      end
      checks++;
      if (if_stall !== !exp_if_rdy || if_ready !== exp_if_rdy) begin
        errors++; $display("FAIL starve_stall c=%0d: got stall=%b rdy=%b want stall=%b rdy=%b",
                           c, if_stall, if_ready, !exp_if_rdy, exp_if_rdy);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1008;
    #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h402}) begin
      errors++; $display("FAIL midrst_grant: got en=%b addr=%h want 1 402", mem_en, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({d_ready, if_ready, err, mem_en, mem_we, mem_addr, mem_wdata} !== 69'h0) begin
      errors++; $display("FAIL midrst_outs: got rdy=%b en=%b addr=%h wdata=%h want all 0",
                         d_ready, mem_en, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_addr, d_ready, d_rdata} !== {1'b1, 32'h402, 1'b0, 32'h0}) begin
      errors++; $display("FAIL midrst_regrant: got en=%b addr=%h rdy=%b data=%h want 1 402 0 0",
                         mem_en, mem_addr, d_ready, d_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, shadow[32'h402]}) begin
      errors++; $display("FAIL midrst_resp: got rdy=%b data=%h want 1 %h", d_ready, d_rdata, shadow[32'h402]);
    end
    d_req = 1'b0;
  endtask

  task automatic test_bounds();
    logic        exp_en, exp_err;
    logic [31:0] exp_word, exp_rd;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    exp_en = 1'b0; exp_err = 1'b1; exp_word = shadow[32'h40];
`else
    exp_en = 1'b1; exp_err = 1'b0; exp_word = 32'hCAFE_F00D;
`endif
    reset_dut();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if ({mem_en, mem_we} !== {exp_en, exp_en}) begin
      errors++; $display("FAIL bounds_wr_en: got en=%b we=%b want %b %b", mem_en, mem_we, exp_en, exp_en);
    end
    @(negedge clk); #1;
    checks++;
    if ({d_ready, err, d_rdata} !== {1'b1, exp_err, 32'h0}) begin
      errors++; $display("FAIL bounds_wr_resp: got rdy=%b err=%b data=%h want 1 %b 0", d_ready, err, d_rdata, exp_err);
    end
    checks++;
    if (mem[32'h40] !== exp_word) begin
      errors++; $display("FAIL bounds_mem: got %h want %h", mem[32'h40], exp_word);
    end
    shadow[32'h40] = exp_word;
    d_req = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'hFFF;
    #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h3FF}) begin
      errors++; $display("FAIL bounds_text_hi: got en=%b addr=%h want 1 3ff", mem_en, mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({if_ready, err, if_rdata} !== {1'b1, 1'b0, shadow[32'h3FF]}) begin
      errors++; $display("FAIL bounds_text_resp: got rdy=%b err=%b data=%h want 1 0 %h",
                         if_ready, err, if_rdata, shadow[32'h3FF]);
    end
    if_req = 1'b0;
    exp_rd = exp_err ? 32'h0 : shadow[32'h3FF];
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hFFC;
    #1;
    checks++;
    if (mem_en !== exp_en) begin
      errors++; $display("FAIL bounds_rd_en: got %b want %b", mem_en, exp_en);
    end
    @(negedge clk); #1;
    checks++;
    if ({d_ready, err, d_rdata} !== {1'b1, exp_err, exp_rd}) begin
      errors++; $display("FAIL bounds_rd_resp: got rdy=%b err=%b data=%h want 1 %b %h", d_ready, err, d_rdata, exp_err, exp_rd);
    end
    d_req = 1'b0;
  endtask

  // Reference: the memory is free on any cycle that does not follow a grant; a free cycle
  // grants by priority (data first unless the fetch port has lost LIMIT times in a row).
  task automatic test_random();
    bit          pend_if, pend_d, busy, busy_d, p_we, g_if, g_d, e_if_rdy, e_d_rdy;
    logic [31:0] p_if_addr, p_d_addr, p_wdata, busy_data, exp_if_rd, exp_d_rd, exp_addr;
    logic [6:0]  exp_ctl, got_ctl;
    int          losses, idx;
    reset_dut();
    pend_if = 0; pend_d = 0; busy = 0; busy_d = 0; p_we = 0; losses = 0;
    exp_if_rd = 32'h0; exp_d_rd = 32'h0; busy_data = 32'h0;
    p_if_addr = 32'h0; p_d_addr = 32'h1000; p_wdata = 32'h0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!pend_if && $urandom_range(0, 2) != 0) begin
        pend_if   = 1;
        p_if_addr = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(0, 3));
      end
      if (!pend_d && $urandom_range(0, 2) != 0) begin
        pend_d   = 1;
        p_we     = $urandom_range(0, 1) == 1;
        p_d_addr = 32'h1000 + ((32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(0, 3)));
        p_wdata  = $urandom;
      end
      if_req  = pend_if;
      if_addr = pend_if ? p_if_addr : $urandom;
      d_req   = pend_d;
      d_we    = pend_d ? p_we : 1'($urandom_range(0, 1));
      d_addr  = pend_d ? p_d_addr : $urandom;
      d_wdata = pend_d ? p_wdata : $urandom;
      if (busy && $urandom_range(0, 3) == 0) begin
        if (busy_d) d_req = 1'b0;
        else        if_req = 1'b0;
      end
      #1;
      e_if_rdy = busy && !busy_d;
      e_d_rdy  = busy && busy_d;
      if (e_if_rdy) exp_if_rd = busy_data;
      if (e_d_rdy)  exp_d_rd  = busy_data;
      g_if = 0; g_d = 0;
      if (!busy) begin
        if (pend_if && pend_d) begin
          if (losses == LIMIT) g_if = 1;
          else                 g_d  = 1;
        end else begin
          g_if = pend_if;
          g_d  = pend_d;
        end
      end
      exp_ctl = {g_if || g_d, g_d && p_we, e_if_rdy, e_d_rdy, 1'b0, if_req && !e_if_rdy, d_req && !e_d_rdy};
      got_ctl = {mem_en, mem_we, if_ready, d_ready, err, if_stall, d_stall};
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++; $display("FAIL rand_ctl c=%0d: got en/we/ird/drd/err/ist/dst=%b want %b", c, got_ctl, exp_ctl);
      end
      checks++;
      if ({if_rdata, d_rdata} !== {exp_if_rd, exp_d_rd}) begin
        errors++; $display("FAIL rand_rdata c=%0d: got %h/%h want %h/%h", c, if_rdata, d_rdata, exp_if_rd, exp_d_rd);
      end
      if (g_if || g_d) begin
        exp_addr = (g_if ? p_if_addr : p_d_addr) >> 2;
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++; $display("FAIL rand_addr c=%0d: got %h want %h", c, mem_addr, exp_addr);
        end
      end
      if (g_d && p_we) begin
        checks++;
        if (mem_wdata !== p_wdata) begin
          errors++; $display("FAIL rand_wdata c=%0d: got %h want %h", c, mem_wdata, p_wdata);
        end
      end
      if (busy) begin
        busy = 0;
        if (busy_d) pend_d = 0;
        else        pend_if = 0;
      end else if (g_if) begin
        busy = 1; busy_d = 0; losses = 0;
        idx = int'(p_if_addr[12:2]);
        busy_data = shadow[idx];
      end else if (g_d) begin
        busy = 1; busy_d = 1;
        idx = int'(p_d_addr[12:2]);
        if (p_we) begin
          busy_data   = 32'h0;
          shadow[idx] = p_wdata;
        end else begin
          busy_data = shadow[idx];
        end
        if (pend_if && losses < LIMIT) losses++;
      end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      shadow[i] = (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
      mem[i] <= (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    end
    test_reset();
    test_fetch();
    test_write_read();
    test_starve();
    test_reset_mid();
    test_bounds();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
